// File: rtl/status_wr_pkg.sv
// Shared types and constants for the status-record write sequencer.
package status_wr_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StWait  = 2'd2
  } wr_state_e;

  localparam int unsigned WR_DATA_W = 256;

  // Ring geometry for the default configuration; instances derive their own via the helpers.
  localparam int unsigned DEF_DATA_W       = 64;
  localparam int unsigned DEF_REGION_BYTES = 4096;
  localparam logic [31:0] DEF_BASE_ADDR    = 32'h1000_0000;
  localparam int unsigned BYTES_PER_REC    = DEF_DATA_W / 8;
  localparam logic [31:0] RING_END         = DEF_BASE_ADDR + 32'(DEF_REGION_BYTES);

  function automatic int unsigned bytes_per_rec(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/status_wr_ctrl_if.sv
// Write-request channel between the sequencer (master) and the AXI write engine (slave).
interface status_wr_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  import status_wr_pkg::*;

  logic                 WR_START;
  logic [ADDR_W-1:0]    WR_ADRS;
  logic [WR_DATA_W-1:0] WR_DATA_IN;
  logic                 WR_DONE;

  modport master (
    output WR_START,
    output WR_ADRS,
    output WR_DATA_IN,
    input  WR_DONE
  );

  modport slave (
    input  WR_START,
    input  WR_ADRS,
    input  WR_DATA_IN,
    output WR_DONE
  );

endinterface

// File: rtl/status_wr_fifo.sv
// Show-ahead synchronous FIFO with flush; full/empty derived from a registered occupancy count.
module status_wr_fifo #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     count_q;
  logic              do_push, do_pop;

  assign full    = (count_q == (PtrW + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/status_wr_ctrl.sv
// Status-record write sequencer: buffers records and issues one START/DONE write each into a ring.
// Optional WAIT-state timeout is enabled by defining STATUS_WR_TIMEOUT_EN.
module status_wr_ctrl
  import status_wr_pkg::*;
#(
  parameter int unsigned       DATA_W       = 64,
  parameter int unsigned       ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 32'h1000_0000,
  parameter int unsigned       REGION_BYTES = 4096,
  parameter int unsigned       FIFO_DEPTH   = 4,
  parameter int unsigned       DONE_TIMEOUT = 1024
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  status_wr_ctrl_if.master  wr,
  output logic              busy,
  output logic [31:0]       wr_count,
  output logic [15:0]       drop_count,
  output logic              timeout_err
);

  localparam int unsigned       RecBytes    = bytes_per_rec(DATA_W);
  localparam logic [ADDR_W-1:0] RingEndAddr = ADDR_W'(BASE_ADDR + ADDR_W'(REGION_BYTES));

  wr_state_e         state_q, state_d;
  logic [ADDR_W-1:0] adrs_q, adrs_next;
  logic [DATA_W-1:0] data_q, head;
  logic [31:0]       wr_count_q;
  logic [15:0]       drop_count_q;
  logic              abort_q, abort_d;
  logic              full, empty, push, pop;
  logic              timeout_hit, wait_exit, done_ok, latch;

  assign in_ready = !full;
  assign push     = in_valid && !full && !clear;

  status_wr_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .flush (clear),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!empty && !clear) state_d = StStart;
      StStart: state_d = StWait;
      StWait:  if (wr.WR_DONE || timeout_hit) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr.WR_START = (state_q == StStart);
    pop         = (state_q == StStart);
    busy        = (state_q != StIdle) || !empty;
  end

  assign wait_exit = (state_q == StWait) && (wr.WR_DONE || timeout_hit);
  assign done_ok   = (state_q == StWait) && wr.WR_DONE && !abort_q;
  assign latch     = (state_q == StIdle) && !empty && !clear;
  assign adrs_next = (adrs_q + ADDR_W'(RecBytes) == RingEndAddr) ? BASE_ADDR
                                                                  : adrs_q + ADDR_W'(RecBytes);

  // A clear during an in-flight write lets it finish but suppresses its bookkeeping.
  always_comb begin
    abort_d = abort_q;
    if (wait_exit)                          abort_d = 1'b0;
    else if (clear && state_q != StIdle)    abort_d = 1'b1;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      adrs_q       <= BASE_ADDR;
      data_q       <= '0;
      wr_count_q   <= '0;
      drop_count_q <= '0;
      abort_q      <= 1'b0;
    end else begin
      abort_q <= abort_d;
      if (latch) data_q <= head;
      if (clear) begin
        adrs_q       <= BASE_ADDR;
        wr_count_q   <= '0;
        drop_count_q <= '0;
      end else begin
        if (done_ok) begin
          adrs_q     <= adrs_next;
          wr_count_q <= wr_count_q + 32'd1;
        end
        if (in_valid && full && drop_count_q != 16'hFFFF) begin
          drop_count_q <= drop_count_q + 16'd1;
        end
      end
    end
  end

  assign wr.WR_ADRS    = adrs_q;
  assign wr.WR_DATA_IN = WR_DATA_W'(data_q);
  assign wr_count      = wr_count_q;
  assign drop_count    = drop_count_q;

`ifdef STATUS_WR_TIMEOUT_EN
  logic [31:0] wait_cnt_q;
  logic        timeout_err_q;

  assign timeout_hit = (state_q == StWait) && !wr.WR_DONE &&
                       (wait_cnt_q == 32'(DONE_TIMEOUT - 1));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wait_cnt_q <= (state_q == StWait) ? wait_cnt_q + 32'd1 : '0;
      if (clear)            timeout_err_q <= 1'b0;
      else if (timeout_hit) timeout_err_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic unused_done_timeout;
  assign unused_done_timeout = ^DONE_TIMEOUT;
  assign timeout_hit         = 1'b0;
  assign timeout_err         = 1'b0;
`endif

endmodule
